alu_stage: RTL and testbench

//  Arithmetic stage fed by the gpreg LHS/RHS operand buses. Latches operands and
//  an opcode on a clock edge and holds the result in an internal result register.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_stage.sv | 148 ++++++++++++++
 tb/tb_alu_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM definitions for the ALU stage.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_INC   = 4'h8,
    OP_DEC   = 4'h9,
    OP_MUL   = 4'hA,
    OP_PASSL = 4'hB
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  // Place individual flag bits at their architectural positions.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic z, input logic n,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, done_c on the last step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned MUL_CYC = DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   lhs,
  input  logic [WIDTH-1:0]   rhs,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(MUL_CYC + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_step;

  assign acc_step  = acc + (mplier[0] ? mcand : '0);
  assign done_c    = active && (cnt == CNT_W'(MUL_CYC - 1));
  assign product_c = acc_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, lhs};
      mplier <= rhs;
      acc    <= '0;
    end else if (active) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done_c) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// ALU stage: operand sampling, single-cycle ALU, sequenced MUL, flags and main-bus driver.
module alu_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned MUL_CYC = DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  LHS_in,
  input  logic [WIDTH-1:0]  RHS_in,
  input  logic [OP_W-1:0]   OP,
  input  logic              LOAD_bar,
  input  logic              ASSERT_MAIN_bar,
  output logic [WIDTH-1:0]  MAIN_out,
  output logic [FLAG_W-1:0] FLAGS,
  output logic              BUSY,
  output logic [WIDTH-1:0]  display_value
);

  alu_state_t        state, state_nxt;
  alu_op_t           op_c;
  logic [WIDTH-1:0]  result, result_nxt;
  logic [FLAG_W-1:0] flags, flags_nxt;
  logic              busy_q;

  logic [WIDTH:0]    sum, diff, incr, decr;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c, alu_v, alu_valid;

  logic              mul_start_c, mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;

  assign op_c = alu_op_t'(OP);
  assign sum  = {1'b0, LHS_in} + {1'b0, RHS_in};
  assign diff = {1'b0, LHS_in} - {1'b0, RHS_in};
  assign incr = {1'b0, LHS_in} + (WIDTH+1)'(1);
  assign decr = {1'b0, LHS_in} - (WIDTH+1)'(1);

  alu_mul_seq #(.WIDTH(WIDTH), .MUL_CYC(MUL_CYC)) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .start    (mul_start_c),
    .lhs      (LHS_in),
    .rhs      (RHS_in),
    .done_c   (mul_done_c),
    .product_c(mul_prod_c)
  );

  // Single-cycle ALU; C is borrow for subtraction, V is signed overflow.
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_valid = 1'b1;
    case (op_c)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (LHS_in[WIDTH-1] == RHS_in[WIDTH-1]) && (sum[WIDTH-1] != LHS_in[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (LHS_in[WIDTH-1] != RHS_in[WIDTH-1]) && (diff[WIDTH-1] != LHS_in[WIDTH-1]);
      end
      OP_AND:   alu_res = LHS_in & RHS_in;
      OP_OR:    alu_res = LHS_in | RHS_in;
      OP_XOR:   alu_res = LHS_in ^ RHS_in;
      OP_NOT:   alu_res = ~LHS_in;
      OP_SHL: begin
        alu_res = {LHS_in[WIDTH-2:0], 1'b0};
        alu_c   = LHS_in[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, LHS_in[WIDTH-1:1]};
        alu_c   = LHS_in[0];
      end
      OP_INC: begin
        alu_res = incr[WIDTH-1:0];
        alu_c   = incr[WIDTH];
        alu_v   = !LHS_in[WIDTH-1] && incr[WIDTH-1];
      end
      OP_DEC: begin
        alu_res = decr[WIDTH-1:0];
        alu_c   = decr[WIDTH];
        alu_v   = LHS_in[WIDTH-1] && !decr[WIDTH-1];
      end
      OP_PASSL: alu_res = LHS_in;
      default:  alu_valid = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and next result/flags; loads during MUL are dropped.
  always_comb begin
    state_nxt   = state;
    result_nxt  = result;
    flags_nxt   = flags;
    mul_start_c = 1'b0;
    case (state)
      IDLE: begin
        if (!LOAD_bar) begin
          if (op_c == OP_MUL) begin
            mul_start_c = 1'b1;
            state_nxt   = MUL;
          end else if (alu_valid) begin
            result_nxt = alu_res;
            flags_nxt  = pack_flags(alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v);
          end
        end
      end
      MUL: begin
        if (mul_done_c) begin
          result_nxt = mul_prod_c[WIDTH-1:0];
          flags_nxt  = pack_flags(mul_prod_c[WIDTH-1:0] == '0, mul_prod_c[WIDTH-1],
                                  |mul_prod_c[2*WIDTH-1:WIDTH], 1'b0);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result <= '0;
      flags  <= '0;
      busy_q <= 1'b0;
    end else begin
      result <= result_nxt;
      flags  <= flags_nxt;
      busy_q <= (state_nxt == MUL);
    end
  end

  assign display_value = result;
  assign FLAGS         = flags;
  assign BUSY          = busy_q;

  // Bus is released while multiplying so partial state never reaches the main bus.
  assign MAIN_out = (!ASSERT_MAIN_bar && !busy_q) ? result : 'z;

endmodule

// File: tb/tb_alu_stage.sv
// Directed, table-driven bench for alu_stage; the main bus is pulled up so a released bus reads FF.
module tb_alu_stage;
  import alu_pkg::*;

  logic       CLK;
  logic       RST;
  logic [7:0] LHS_in, RHS_in;
  logic [3:0] OP;
  logic       LOAD_bar, ASSERT_MAIN_bar;
  tri   [7:0] main_bus;
  logic [3:0] FLAGS;
  logic       BUSY;
  logic [7:0] display_value;

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (main_bus[g]);
  end

  alu_stage #(.WIDTH(8), .MUL_CYC(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .LHS_in         (LHS_in),
    .RHS_in         (RHS_in),
    .OP             (OP),
    .LOAD_bar       (LOAD_bar),
    .ASSERT_MAIN_bar(ASSERT_MAIN_bar),
    .MAIN_out       (main_bus),
    .FLAGS          (FLAGS),
    .BUSY           (BUSY),
    .display_value  (display_value)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic [7:0] exp_res;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_op(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r);
    OP = op; LHS_in = l; RHS_in = r; LOAD_bar = 1'b0;
    tick();
    LOAD_bar = 1'b1;
  endtask

  task automatic check_state(input string name, input logic [7:0] res, input logic [3:0] fl,
                             input logic busy);
    check({name, ".result"}, 16'(display_value), 16'(res));
    check({name, ".flags"},  16'(FLAGS), 16'(fl));
    check({name, ".busy"},   16'(BUSY), 16'(busy));
  endtask

  initial begin
    // {op, lhs, rhs, result, {Z,N,C,V}}
    vecs[0]  = '{OP_ADD,   8'hA8, 8'h60, 8'h08, 4'b0010};
    vecs[1]  = '{OP_SUB,   8'h10, 8'h10, 8'h00, 4'b1000};
    vecs[2]  = '{OP_SHL,   8'h81, 8'h00, 8'h02, 4'b0010};
    vecs[3]  = '{OP_SHR,   8'h01, 8'h00, 8'h00, 4'b1010};
    vecs[4]  = '{OP_ADD,   8'h7F, 8'h01, 8'h80, 4'b0101};
    vecs[5]  = '{OP_SUB,   8'h00, 8'h01, 8'hFF, 4'b0110};
    vecs[6]  = '{OP_SUB,   8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[7]  = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[8]  = '{OP_OR,    8'hF0, 8'h0C, 8'hFC, 4'b0100};
    vecs[9]  = '{OP_XOR,   8'hFF, 8'hFF, 8'h00, 4'b1000};
    vecs[10] = '{OP_NOT,   8'h0F, 8'h00, 8'hF0, 4'b0100};
    vecs[11] = '{OP_INC,   8'hFF, 8'h00, 8'h00, 4'b1010};
    vecs[12] = '{OP_INC,   8'h7F, 8'h00, 8'h80, 4'b0101};
    vecs[13] = '{OP_DEC,   8'h00, 8'h00, 8'hFF, 4'b0110};
    vecs[14] = '{OP_DEC,   8'h80, 8'h00, 8'h7F, 4'b0001};
    vecs[15] = '{4'hD,     8'h12, 8'h34, 8'h7F, 4'b0001};
    vecs[16] = '{OP_PASSL, 8'h5A, 8'hC3, 8'h5A, 4'b0000};
    vecs[17] = '{4'hF,     8'h00, 8'h00, 8'h5A, 4'b0000};

    RST = 1'b1; LHS_in = '0; RHS_in = '0; OP = '0;
    LOAD_bar = 1'b1; ASSERT_MAIN_bar = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    check_state("reset", 8'h00, 4'b0000, 1'b0);
    check("reset.bus_released", 16'(main_bus), 16'h00FF);

    for (int i = 0; i < 18; i++) begin
      load_op(vecs[i].op, vecs[i].lhs, vecs[i].rhs);
      check_state($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_flags, 1'b0);
    end

    // Bus driver follows ASSERT_MAIN_bar combinationally.
    load_op(OP_ADD, 8'hA8, 8'h60);
    ASSERT_MAIN_bar = 1'b0; #1;
    check("add.bus", 16'(main_bus), 16'h0008);
    ASSERT_MAIN_bar = 1'b1; #1;
    check("add.bus_released", 16'(main_bus), 16'h00FF);

    // Held result with LOAD_bar high.
    load_op(OP_SUB, 8'h10, 8'h10);
    OP = OP_ADD; LHS_in = 8'h8A; RHS_in = 8'h01;
    tick();
    check_state("hold", 8'h00, 4'b1000, 1'b0);

    // Load and assert together: old result until the edge, new one after.
    ASSERT_MAIN_bar = 1'b0;
    OP = OP_ADD; LHS_in = 8'h01; RHS_in = 8'h01; LOAD_bar = 1'b0; #1;
    check("simul.bus_before", 16'(main_bus), 16'h0000);
    tick();
    LOAD_bar = 1'b1;
    check("simul.bus_after", 16'(main_bus), 16'h0002);

    // MUL 0C*0B with a stray load mid-way and the bus asserted throughout.
    load_op(OP_MUL, 8'h0C, 8'h0B);
    check("mul1.busy_start", 16'(BUSY), 16'h0001);
    check("mul1.bus_released", 16'(main_bus), 16'h00FF);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        OP = OP_ADD; LHS_in = 8'h01; RHS_in = 8'h01; LOAD_bar = 1'b0;
      end
      tick();
      LOAD_bar = 1'b1;
      if (k < 8) begin
        check($sformatf("mul1.busy_t%0d", k), 16'(BUSY), 16'h0001);
        check($sformatf("mul1.result_t%0d", k), 16'(display_value), 16'h0002);
      end
    end
    check_state("mul1.done", 8'h84, 4'b0100, 1'b0);
    check("mul1.bus", 16'(main_bus), 16'h0084);
    tick();
    check_state("mul1.not_queued", 8'h84, 4'b0100, 1'b0);
    ASSERT_MAIN_bar = 1'b1;

    // MUL 20*10 overflows into the high byte.
    load_op(OP_MUL, 8'h20, 8'h10);
    for (int k = 1; k <= 8; k++) tick();
    check_state("mul2.done", 8'h00, 4'b1010, 1'b0);

    // Same MUL aborted by reset at tick 4.
    load_op(OP_MUL, 8'h20, 8'h10);
    for (int k = 1; k <= 3; k++) tick();
    check("mul3.busy_before_rst", 16'(BUSY), 16'h0001);
    RST = 1'b1; #1;
    check_state("mul3.rst", 8'h00, 4'b0000, 1'b0);
    tick();
    RST = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check_state("mul3.after_rst", 8'h00, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
